// File: rtl/mpdiv.sv
// Signed fractional divider: quotient = (dividend <<< FRAC) / divisor.
// Restoring shift-subtract, one bit per clock, fixed 40-edge latency, with saturation.
module mpdiv #(
  parameter int W_N  = 24,
  parameter int W_D  = 16,
  parameter int FRAC = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W_N-1:0] dividend_i,
  input  logic [W_D-1:0] divisor_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [W_N-1:0] quotient_o,
  output logic           ovf_o,
  output logic           divz_o
);
  localparam int WQ = W_N + FRAC;
  localparam int WC = $clog2(WQ);
  localparam logic [WQ-1:0] MAG_NEG = WQ'(1) << (W_N - 1);
  localparam logic [WQ-1:0] MAG_POS = MAG_NEG - WQ'(1);
  localparam logic [W_N-1:0] Q_MAX = {1'b0, {(W_N-1){1'b1}}};
  localparam logic [W_N-1:0] Q_MIN = {1'b1, {(W_N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state;
  logic [WQ-1:0] dvd;
  logic [WQ-1:0] quo;
  logic [W_D-1:0] dsr;
  logic [W_D:0]  rem;
  logic [WC-1:0] cnt;
  logic          sign;
  logic          nz;
  logic          dz;

  logic [W_N-1:0] a_mag;
  logic [W_D-1:0] b_mag;
  logic [W_D:0]   rem_sh;
  logic           ge;

  // Two's-complement negation in the operand width makes |min| exact as unsigned.
  assign a_mag  = dividend_i[W_N-1] ? -dividend_i : dividend_i;
  assign b_mag  = divisor_i[W_D-1] ? -divisor_i : divisor_i;
  assign rem_sh = {rem[W_D-1:0], dvd[WQ-1]};
  assign ge     = rem_sh >= {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready_o    <= 1'b1;
      valid_o    <= 1'b0;
      quotient_o <= '0;
      ovf_o      <= 1'b0;
      divz_o     <= 1'b0;
      dvd        <= '0;
      quo        <= '0;
      dsr        <= '0;
      rem        <= '0;
      cnt        <= '0;
      sign       <= 1'b0;
      nz         <= 1'b0;
      dz         <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            nz      <= |dividend_i;
            dz      <= ~|divisor_i;
            // A zero dividend forces a positive sign so the result is never -0.
            sign    <= (|dividend_i) & (dividend_i[W_N-1] ^ divisor_i[W_D-1]);
            dvd     <= {a_mag, {FRAC{1'b0}}};
            dsr     <= b_mag;
            rem     <= '0;
            quo     <= '0;
            cnt     <= WC'(WQ - 1);
            ready_o <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          if (ge) begin
            rem <= rem_sh - {1'b0, dsr};
            quo <= {quo[WQ-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[WQ-2:0], 1'b0};
          end
          if (cnt == '0) state <= FIN;
          else           cnt <= cnt - WC'(1);
        end
        FIN: begin
          valid_o <= 1'b1;
          ready_o <= 1'b1;
          state   <= IDLE;
          if (dz) begin
            divz_o     <= 1'b1;
            ovf_o      <= 1'b0;
            quotient_o <= !nz ? '0 : (sign ? Q_MIN : Q_MAX);
          end else begin
            divz_o <= 1'b0;
            if (!sign) begin
              ovf_o      <= quo > MAG_POS;
              quotient_o <= (quo > MAG_POS) ? Q_MAX : quo[W_N-1:0];
            end else begin
              ovf_o      <= quo > MAG_NEG;
              quotient_o <= (quo > MAG_NEG) ? Q_MIN : -quo[W_N-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
